// File: rtl/fsm_cmd_conditioner_pkg.sv
// ============================================================================
// Module      : fsm_cmd_pkg
// Description : Shared types and constants for the user-command conditioner.
//               Holds the debounce FSM state type, the command width and the
//               highest command code the downstream 4-state FSM accepts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_cmd_pkg;

    // Two-bit encoding; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        COMMIT = 2'b10,
        SPARE  = 2'b11
    } cond_state_t;

    localparam int          CMD_W         = 3;
    localparam logic [2:0]  CMD_LEGAL_MAX = 3'd3;

endpackage : fsm_cmd_pkg

`default_nettype wire

// File: rtl/fsm_cmd_conditioner_if.sv
// ============================================================================
// Module      : fsm_cmd_conditioner_if
// Description : Command bus between the raw user command source, the
//               conditioner and its consumer.
//   raw_in      - asynchronous 3-bit user command (may bounce)
//   cmd_out     - committed command
//   cmd_valid   - one-cycle strobe when cmd_out changes
//   busy        - conditioner is not idle
//   illegal_cmd - one-cycle strobe on a rejected code (CMD_LEGAL_FILTER_EN)
// Modports    : master = conditioner side, slave = source/consumer side.
// Macro       : CMD_LEGAL_FILTER_EN adds illegal_cmd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_cmd_conditioner_if;
    import fsm_cmd_pkg::*;

    logic [CMD_W-1:0] raw_in;
    logic [CMD_W-1:0] cmd_out;
    logic             cmd_valid;
    logic             busy;
`ifdef CMD_LEGAL_FILTER_EN
    logic             illegal_cmd;
`endif

`ifdef CMD_LEGAL_FILTER_EN
    modport master (input raw_in, output cmd_out, output cmd_valid, output busy, output illegal_cmd);
    modport slave  (output raw_in, input cmd_out, input cmd_valid, input busy, input illegal_cmd);
`else
    modport master (input raw_in, output cmd_out, output cmd_valid, output busy);
    modport slave  (output raw_in, input cmd_out, input cmd_valid, input busy);
`endif

endinterface : fsm_cmd_conditioner_if

`default_nettype wire

// File: rtl/fsm_cmd_conditioner_sync.sv
// ============================================================================
// Module      : cmd_sync
// Description : STAGES-deep flop chain bringing an asynchronous bus into the
//               clk domain. All flops reset asynchronously to 0.
// Ports       : clk, rst_n (async active-low), d (async input),
//               q (last stage, synchronised output)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain[0] <= '0;
        end else begin
            r_chain[0] <= d;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_chain[g] <= '0;
            end else begin
                r_chain[g] <= r_chain[g-1];
            end
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : cmd_sync

`default_nettype wire

// File: rtl/fsm_cmd_conditioner.sv
// ============================================================================
// Module      : fsm_cmd_conditioner
// Description : Synchronises and debounces the 3-bit user command and
//               presents a stable registered command plus a one-cycle update
//               strobe. A new code must be seen unchanged for
//               DEBOUNCE_CYCLES synchronised cycles before it commits.
// Ports       : clk, rst_n (async active-low),
//               bus (fsm_cmd_conditioner_if.master: raw_in, cmd_out,
//               cmd_valid, busy [, illegal_cmd])
// Parameters  : SYNC_STAGES (2..4), DEBOUNCE_CYCLES (>= 1)
// Macro       : CMD_LEGAL_FILTER_EN - codes 4..7 are rejected instead of
//               committed and flagged on illegal_cmd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_cmd_conditioner
    import fsm_cmd_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fsm_cmd_conditioner_if.master bus
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    cond_state_t      r_state,     w_state_nxt;
    logic [CMD_W-1:0] r_cand,      w_cand_nxt;
    logic [CMD_W-1:0] r_cmd,       w_cmd_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic             r_valid,     w_valid_nxt;
`ifdef CMD_LEGAL_FILTER_EN
    logic             r_illegal,   w_illegal_nxt;
`endif
    logic [CMD_W-1:0] w_sync_in;

    cmd_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (CMD_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.raw_in),
        .q     (w_sync_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cand    <= '0;
            r_cmd     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
`ifdef CMD_LEGAL_FILTER_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
`ifdef CMD_LEGAL_FILTER_EN
            r_illegal <= w_illegal_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cand_nxt    = r_cand;
        w_cmd_nxt     = r_cmd;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = 1'b0;
`ifdef CMD_LEGAL_FILTER_EN
        w_illegal_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_sync_in != r_cmd) begin
                    w_cand_nxt  = w_sync_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_sync_in == r_cmd) begin
                    // Input bounced back to the committed code: abandon.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_sync_in != r_cand) begin
                    // A different code appeared: restart the stability window.
                    w_cand_nxt  = w_sync_in;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_cnt_last) begin
                    // >= rather than == keeps the counter from ever wrapping.
`ifdef CMD_LEGAL_FILTER_EN
                    if (r_cand > CMD_LEGAL_MAX) begin
                        w_state_nxt   = IDLE;
                        w_cnt_nxt     = '0;
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = COMMIT;
                    end
`else
                    w_state_nxt = COMMIT;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                w_cmd_nxt   = r_cand;
                w_valid_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                // Unused encoding: recover without touching the command.
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.cmd_out     = r_cmd;
    assign bus.cmd_valid   = r_valid;
    assign bus.busy        = (r_state != IDLE);
`ifdef CMD_LEGAL_FILTER_EN
    assign bus.illegal_cmd = r_illegal;
`endif

endmodule : fsm_cmd_conditioner

`default_nettype wire

// File: tb/tb_fsm_cmd_conditioner.sv
// ============================================================================
// Module      : tb_fsm_cmd_conditioner
// Description : Directed self-checking bench for fsm_cmd_conditioner with
//               default parameters (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, so a
//               held step commits 8 rising edges after it is driven).
//               Honours CMD_LEGAL_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_cmd_conditioner;
    import fsm_cmd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsm_cmd_conditioner_if bus ();

    fsm_cmd_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int edges;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cmd_valid pulses, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.cmd_valid === 1'b1) n_valid++;
    end

    // Counts rising edges until cmd_valid is seen; -1 if the bound expires.
    task automatic wait_valid(output int e);
        e = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.cmd_valid === 1'b1) begin
                e = k;
                break;
            end
        end
    endtask

    initial begin
        bus.raw_in = 3'd0;
        #1;
        check("reset_cmd_out",   32'(bus.cmd_out),   32'd0);
        check("reset_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with raw_in held at 0.
        n_valid = 0;
        repeat (20) @(negedge clk);
        check("idle_cmd_out", 32'(bus.cmd_out), 32'd0);
        check("idle_valids",  32'(n_valid),     32'd0);
        check("idle_busy",    32'(bus.busy),    32'd0);

        // Short pulse 0->2 for 3 cycles: must not commit.
        n_valid = 0;
        @(negedge clk) bus.raw_in = 3'd2;
        repeat (3) @(negedge clk);
        check("pulse_busy_mid", 32'(bus.busy), 32'd1);
        bus.raw_in = 3'd0;
        repeat (10) @(negedge clk);
        check("pulse_valids",  32'(n_valid),     32'd0);
        check("pulse_cmd_out", 32'(bus.cmd_out), 32'd0);
        check("pulse_busy",    32'(bus.busy),    32'd0);

        // Held step 0->3: commits 8 edges later, one-cycle strobe.
        n_valid = 0;
        @(negedge clk) bus.raw_in = 3'd3;
        wait_valid(edges);
        check("step_latency", 32'(edges),       32'd8);
        check("step_cmd_out", 32'(bus.cmd_out), 32'd3);
        @(posedge clk);
        #1;
        check("step_valid_width", 32'(bus.cmd_valid), 32'd0);
        check("step_busy_after",  32'(bus.busy),      32'd0);
        repeat (10) @(negedge clk);
        check("step_valids", 32'(n_valid), 32'd1);

        // Toggle 1,2 every cycle for 10 cycles, then hold 2.
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.raw_in = (i % 2 == 0) ? 3'd1 : 3'd2;
        end
        wait_valid(edges);
        check("toggle_latency", 32'(edges),       32'd8);
        check("toggle_cmd_out", 32'(bus.cmd_out), 32'd2);
        repeat (12) @(negedge clk);
        check("toggle_valids", 32'(n_valid), 32'd1);

        // Asynchronous reset while settling on candidate 3.
        @(negedge clk) bus.raw_in = 3'd3;
        repeat (4) @(posedge clk);
        #1;
        check("settle_busy", 32'(bus.busy),  32'd1);
        check("settle_cand", 32'(dut.r_cand), 32'd3);
        rst_n = 1'b0;
        #1;
        check("arst_cmd_out",   32'(bus.cmd_out),   32'd0);
        check("arst_busy",      32'(bus.busy),      32'd0);
        check("arst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        bus.raw_in = 3'd0;
        @(negedge clk) rst_n = 1'b1;
        n_valid = 0;
        repeat (20) @(negedge clk);
        check("arst_valids",     32'(n_valid),     32'd0);
        check("arst_cmd_out_hd", 32'(bus.cmd_out), 32'd0);

        // Commit code 1, then drive the FSM into the unused encoding.
        @(negedge clk) bus.raw_in = 3'd1;
        wait_valid(edges);
        check("code1_cmd_out", 32'(bus.cmd_out), 32'd1);
        @(negedge clk);
        force dut.r_state = SPARE;
        #1;
        release dut.r_state;
        #1;
        check("spare_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("spare_state_next", 32'(dut.r_state),    32'(IDLE));
        check("spare_cmd_out",    32'(bus.cmd_out),    32'd1);
        check("spare_cmd_valid",  32'(bus.cmd_valid),  32'd0);
        check("spare_busy_next",  32'(bus.busy),       32'd0);

        // Code 6: rejected with filter, committed without.
        n_valid = 0;
        @(negedge clk) bus.raw_in = 3'd6;
`ifdef CMD_LEGAL_FILTER_EN
        begin
            int n_ill;
            int first;
            n_ill = 0;
            first = -1;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                #1;
                if (bus.illegal_cmd === 1'b1) begin
                    n_ill++;
                    if (first < 0) first = k;
                end
            end
            check("illegal_first_edge", 32'(first),       32'd7);
            check("illegal_pulses",     32'(n_ill),       32'd1);
            check("illegal_cmd_out",    32'(bus.cmd_out), 32'd1);
            check("illegal_valids",     32'(n_valid),     32'd0);
        end
`else
        wait_valid(edges);
        check("code6_latency", 32'(edges),       32'd8);
        check("code6_cmd_out", 32'(bus.cmd_out), 32'd6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

endmodule : tb_fsm_cmd_conditioner

`default_nettype wire
